// File: rtl/fxp_div_pkg.sv
// Shared types and helpers for the pipelined signed fixed-point divider.
package fxp_div_pkg;

  // Per-stage control payload. Tag, divisor, residue and quotient travel
  // beside it in parameter-sized vectors.
  typedef struct packed {
    logic valid;
    logic neg;    // sign(x) ^ sign(y)
    logic xneg;   // sign of the dividend; also the sign of the residue
    logic xzero;  // dividend was zero; only consulted on divide-by-zero
    logic dz;     // divisor was zero
  } div_ctrl_t;

  localparam int SAT_W = 64;

  function automatic int div_stages(input int qbits, input int stage_bits);
    return qbits / stage_bits;
  endfunction

  function automatic logic [SAT_W-1:0] sat_max(input int w);
    return (SAT_W'(1) << (w - 1)) - SAT_W'(1);
  endfunction

  function automatic logic [SAT_W-1:0] sat_min(input int w);
    return SAT_W'(1) << (w - 1);
  endfunction

endpackage

// File: rtl/fxp_div_stage.sv
// One restoring-division stage: resolves STAGE_BITS quotient bits, MSB first.
module fxp_div_stage
  import fxp_div_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int QBITS      = 48,
  parameter int STAGE_BITS = 1,
  parameter int TAG_W      = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  div_ctrl_t         i_ctrl,
  input  logic [TAG_W-1:0]  i_tag,
  input  logic [WIDTH-1:0]  i_ay,
  input  logic [WIDTH-1:0]  i_rem,
  input  logic [QBITS-1:0]  i_qd,
  output div_ctrl_t         o_ctrl,
  output logic [TAG_W-1:0]  o_tag,
  output logic [WIDTH-1:0]  o_ay,
  output logic [WIDTH-1:0]  o_rem,
  output logic [QBITS-1:0]  o_qd
);

  logic [WIDTH-1:0] rem_n;
  logic [QBITS-1:0] qd_n;
  logic [WIDTH:0]   trial;

  // qd holds unconsumed dividend bits at the top and resolved quotient bits
  // shifted in at the bottom; after the last stage it is the full quotient.
  always_comb begin
    rem_n = i_rem;
    qd_n  = i_qd;
    trial = '0;
    for (int s = 0; s < STAGE_BITS; s++) begin
      trial = {rem_n, qd_n[QBITS-1]};
      if (trial >= {1'b0, i_ay}) begin
        rem_n = WIDTH'(trial - {1'b0, i_ay});
        qd_n  = {qd_n[QBITS-2:0], 1'b1};
      end else begin
        rem_n = trial[WIDTH-1:0];
        qd_n  = {qd_n[QBITS-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_ctrl <= '0;
    end else if (i_en) begin
      o_ctrl <= i_ctrl;
      o_tag  <= i_tag;
      o_ay   <= i_ay;
      o_rem  <= rem_n;
      o_qd   <= qd_n;
    end
  end

endmodule

// File: rtl/fxp_div_pipe.sv
// Fully pipelined signed Q-format divider z = x / y with saturation and flags.
// Define FXP_DIV_REMAINDER_EN to add the signed residue output o_rem.
module fxp_div_pipe
  import fxp_div_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int FRAC       = 16,
  parameter int STAGE_BITS = 1,
  parameter int TAG_W      = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_y,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_z,
  output logic [TAG_W-1:0] o_tag,
  output logic             o_dz,
  output logic             o_ovf
`ifdef FXP_DIV_REMAINDER_EN
  ,
  output logic [WIDTH-1:0] o_rem
`endif
);

  localparam int QBITS = WIDTH + FRAC;
  localparam int N     = div_stages(QBITS, STAGE_BITS);
  localparam logic [WIDTH-1:0] Z_MAX = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] Z_MIN = WIDTH'(sat_min(WIDTH));

  if ((STAGE_BITS != 1 && STAGE_BITS != 2 && STAGE_BITS != 4) ||
      (QBITS % STAGE_BITS) != 0) begin : g_bad_stage_bits
    $error("fxp_div_pipe: STAGE_BITS must be 1, 2 or 4 and divide WIDTH+FRAC");
  end
  if (FRAC < 0 || FRAC >= WIDTH || WIDTH < 2 || WIDTH > SAT_W) begin : g_bad_width
    $error("fxp_div_pipe: need 0 <= FRAC < WIDTH and 2 <= WIDTH <= 64");
  end

  // Handshake: a transfer happens on any edge where valid & ready are both
  // high; the whole pipe shares one enable, so o_ready depends only on
  // o_valid and i_ready, and a held output never changes while unaccepted.
  logic stall, en;
  assign stall   = o_valid & ~i_ready;
  assign en      = ~stall;
  assign o_ready = en;

  // Capture stage
  logic [WIDTH-1:0] abs_x, abs_y;
  assign abs_x = i_x[WIDTH-1] ? WIDTH'(0) - i_x : i_x;
  assign abs_y = i_y[WIDTH-1] ? WIDTH'(0) - i_y : i_y;

  div_ctrl_t        cap_ctrl;
  logic [TAG_W-1:0] cap_tag;
  logic [WIDTH-1:0] cap_ay;
  logic [QBITS-1:0] cap_qd;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cap_ctrl <= '0;
    end else if (en) begin
      cap_ctrl.valid <= i_valid;
      cap_ctrl.neg   <= i_x[WIDTH-1] ^ i_y[WIDTH-1];
      cap_ctrl.xneg  <= i_x[WIDTH-1];
      cap_ctrl.xzero <= (i_x == '0);
      cap_ctrl.dz    <= (i_y == '0);
      cap_tag        <= i_tag;
      cap_ay         <= abs_y;
      cap_qd         <= QBITS'(abs_x) << FRAC;
    end
  end

  // Iteration stages; element 0 is the capture register, element N the tail.
  div_ctrl_t        pl_ctrl [0:N];
  logic [TAG_W-1:0] pl_tag  [0:N];
  logic [WIDTH-1:0] pl_ay   [0:N];
  logic [WIDTH-1:0] pl_rem  [0:N];
  logic [QBITS-1:0] pl_qd   [0:N];

  assign pl_ctrl[0] = cap_ctrl;
  assign pl_tag[0]  = cap_tag;
  assign pl_ay[0]   = cap_ay;
  assign pl_rem[0]  = '0;
  assign pl_qd[0]   = cap_qd;

  for (genvar i = 0; i < N; i++) begin : g_stage
    fxp_div_stage #(
      .WIDTH(WIDTH), .QBITS(QBITS), .STAGE_BITS(STAGE_BITS), .TAG_W(TAG_W)
    ) u_stage (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_en  (en),
      .i_ctrl(pl_ctrl[i]),
      .i_tag (pl_tag[i]),
      .i_ay  (pl_ay[i]),
      .i_rem (pl_rem[i]),
      .i_qd  (pl_qd[i]),
      .o_ctrl(pl_ctrl[i+1]),
      .o_tag (pl_tag[i+1]),
      .o_ay  (pl_ay[i+1]),
      .o_rem (pl_rem[i+1]),
      .o_qd  (pl_qd[i+1])
    );
  end

  // Output stage: sign restore and saturation
  div_ctrl_t        tail;
  logic [QBITS-1:0] q;
  logic [WIDTH-1:0] q_lo;
  logic [WIDTH-1:0] z_n;
  logic             ovf_n;

  assign tail = pl_ctrl[N];
  assign q    = pl_qd[N];
  assign q_lo = q[WIDTH-1:0];

  always_comb begin
    z_n   = '0;
    ovf_n = 1'b0;
    if (tail.dz) begin
      z_n = tail.xzero ? '0 : (tail.xneg ? Z_MIN : Z_MAX);
    end else if (!tail.neg && q > QBITS'(Z_MAX)) begin
      z_n   = Z_MAX;
      ovf_n = 1'b1;
    end else if (tail.neg && q > QBITS'(Z_MIN)) begin
      z_n   = Z_MIN;
      ovf_n = 1'b1;
    end else begin
      z_n = tail.neg ? WIDTH'(0) - q_lo : q_lo;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_z     <= '0;
      o_tag   <= '0;
      o_dz    <= 1'b0;
      o_ovf   <= 1'b0;
    end else if (en) begin
      o_valid <= tail.valid;
      o_z     <= z_n;
      o_tag   <= pl_tag[N];
      o_dz    <= tail.dz;
      o_ovf   <= ovf_n;
    end
  end

`ifdef FXP_DIV_REMAINDER_EN
  // Residue carries the dividend's sign so that x*2^FRAC = z*y + rem.
  logic [WIDTH-1:0] rem_n;
  assign rem_n = tail.dz ? '0 : (tail.xneg ? WIDTH'(0) - pl_rem[N] : pl_rem[N]);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rem <= '0;
    end else if (en) begin
      o_rem <= rem_n;
    end
  end

  logic unused_tail;
  assign unused_tail = ^pl_ay[N];
`else
  logic unused_tail;
  assign unused_tail = ^{pl_ay[N], pl_rem[N]};
`endif

endmodule

// File: tb/tb_fxp_div_pipe.sv
// Scoreboard bench for fxp_div_pipe (WIDTH=16, FRAC=8, STAGE_BITS=1).
// Latency is measured between the sampling edges where accept and output are seen.
module tb_fxp_div_pipe;

  localparam int W  = 16;
  localparam int F  = 8;
  localparam int SB = 1;
  localparam int TW = 8;
  localparam int N  = (W + F) / SB;
  localparam int L  = N + 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_valid = 1'b0;
  logic          o_ready;
  logic [W-1:0]  i_x = '0;
  logic [W-1:0]  i_y = '0;
  logic [TW-1:0] i_tag = '0;
  logic          o_valid;
  logic          i_ready = 1'b1;
  logic [W-1:0]  o_z;
  logic [TW-1:0] o_tag;
  logic          o_dz;
  logic          o_ovf;
`ifdef FXP_DIV_REMAINDER_EN
  logic [W-1:0]  o_rem;
`endif

  fxp_div_pipe #(.WIDTH(W), .FRAC(F), .STAGE_BITS(SB), .TAG_W(TW)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .i_x    (i_x),
    .i_y    (i_y),
    .i_tag  (i_tag),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_z    (o_z),
    .o_tag  (o_tag),
    .o_dz   (o_dz),
    .o_ovf  (o_ovf)
`ifdef FXP_DIV_REMAINDER_EN
    ,
    .o_rem  (o_rem)
`endif
  );

  // Clock / reset
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [TW-1:0] tag;
    logic [W-1:0]  z;
    logic          dz;
    logic          ovf;
    logic [W-1:0]  rem;
    logic          lat;
    logic [31:0]   cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic lat_en = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference model: plain integer division of x*2^F by y, then clamp.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic [TW-1:0] tag);
    exp_t   e;
    longint xs, ys, ax, ay, q, r, zi;
    e     = '0;
    e.tag = tag;
    xs    = longint'($signed(x));
    ys    = longint'($signed(y));
    ax    = (xs < 0 ? -xs : xs) * (longint'(1) << F);
    ay    = ys < 0 ? -ys : ys;
    if (ys == 0) begin
      e.dz = 1'b1;
      e.z  = (xs > 0) ? 16'h7FFF : (xs < 0) ? 16'h8000 : 16'h0000;
    end else begin
      q  = ax / ay;
      r  = ax - q * ay;
      zi = ((xs < 0) != (ys < 0)) ? -q : q;
      if (zi > 32767) begin
        e.z = 16'h7FFF;  e.ovf = 1'b1;
      end else if (zi < -32768) begin
        e.z = 16'h8000;  e.ovf = 1'b1;
      end else begin
        e.z = zi[W-1:0];
      end
      r     = (xs < 0) ? -r : r;
      e.rem = r[W-1:0];
    end
    return e;
  endfunction

  // Driver tasks (called just after a rising edge)
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic [TW-1:0] tag);
    exp_t e;
    int   n;
    n       = 0;
    i_valid = 1'b1;
    i_x     = x;
    i_y     = y;
    i_tag   = tag;
    e       = model(x, y, tag);
    forever begin
      @(negedge clk);
      if (o_ready) break;
      n++;
      if (n > 500) begin
        chk("send_timeout", 1, 0);
        i_valid = 1'b0;
        return;
      end
    end
    e.lat = lat_en;
    e.cyc = cyc;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int cycles);
    i_valid = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    i_valid = 1'b0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Monitor / scoreboard
  logic          stall_prev = 1'b0;
  logic [W-1:0]  z_s;
  logic [TW-1:0] tag_s;
  logic          dz_s, ovf_s;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      chk("o_ready", o_ready, !(o_valid && !i_ready));
      if (stall_prev) begin
        chk("hold_valid", o_valid, 1);
        chk("hold_z", o_z, z_s);
        chk("hold_tag", o_tag, tag_s);
        chk("hold_flags", {dz_s, ovf_s}, {o_dz, o_ovf});
      end
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("z", o_z, e.z);
          chk("tag", o_tag, e.tag);
          chk("dz", o_dz, e.dz);
          chk("ovf", o_ovf, e.ovf);
`ifdef FXP_DIV_REMAINDER_EN
          chk("rem", o_rem, e.rem);
`endif
          if (e.lat) chk("latency", cyc - e.cyc, L);
        end
      end
      stall_prev = o_valid && !i_ready;
      z_s   = o_z;
      tag_s = o_tag;
      dz_s  = o_dz;
      ovf_s = o_ovf;
    end
  end

  // Stimulus
  logic rand_done;

  initial begin
    logic [W-1:0] rx, ry;
    rand_done = 1'b0;

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", o_valid, 0);
    chk("rst_z", o_z, 0);
    chk("rst_tag", o_tag, 0);
    chk("rst_flags", {o_dz, o_ovf}, 0);
`ifdef FXP_DIV_REMAINDER_EN
    chk("rst_rem", o_rem, 0);
`endif
    chk("rst_ready", o_ready, 1);
    rst = 1'b0;

    // Directed corner cases, back to back
    lat_en = 1'b1;
    send(16'h0300, 16'h0200, 8'h11);
    send(16'hFD00, 16'h0200, 8'h12);
    send(16'h0100, 16'h0300, 8'h13);
    send(16'h0100, 16'h0000, 8'h14);
    send(16'hFF00, 16'h0000, 8'h15);
    send(16'h0000, 16'h0000, 8'h16);
    send(16'h7F00, 16'h0001, 8'h17);
    send(16'h8000, 16'h0100, 8'h18);
    send(16'h8000, 16'hFFFF, 8'h19);
    send(16'h0000, 16'hFE00, 8'h1A);
    drain();

    // Randomized operands, gaps and consumer backpressure
    lat_en = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          case ($urandom_range(0, 7))
            0:       ry = 16'h0000;
            1:       ry = W'($urandom_range(1, 3));
            2:       ry = 16'hFFFF;
            default: ry = W'($urandom);
          endcase
          case ($urandom_range(0, 7))
            0:       rx = 16'h0000;
            1:       rx = 16'h8000;
            2:       rx = 16'h7FFF;
            default: rx = W'($urandom);
          endcase
          send(rx, ry, TW'(i));
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          i_ready = ($urandom_range(0, 3) != 0);
        end
        i_ready = 1'b1;
      end
    join
    drain();

    // Backpressure burst: 40 back-to-back inputs, consumer stalls cycles 30-34
    fork
      begin
        for (int i = 0; i < 40; i++) send(W'($urandom), W'($urandom_range(1, 16'hFFFF)), TW'(i));
        i_valid = 1'b0;
      end
      begin
        repeat (30) @(posedge clk);
        #1;
        i_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        i_ready = 1'b1;
      end
    join
    drain();

    // Reset with ten operations in flight
    lat_en = 1'b1;
    for (int i = 0; i < 10; i++) send(W'($urandom), W'($urandom), TW'(8'h80 + i));
    i_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    repeat (40) begin
      @(negedge clk);
      chk("no_valid_after_rst", o_valid, 0);
    end
    @(posedge clk);
    #1;
    send(16'h0300, 16'h0200, 8'hA5);
    drain();
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
